deinterleaver_ctrl: RTL and testbench

- Sequencing controller for the 802.11a serial deinterleaver datapath (ping-pong symbol RAM plus permutation address logic).
- Latches per-frame rate configuration and accepts one coded bit per clock from the demapper side.
- Steers writes and reads between two symbol banks so one OFDM symbol fills while the previous one drains in deinterleaved order.
- Reports frame progress to the RX control FSM.

---
 rtl/wlan_il_pkg.sv | 32 +++
 rtl/deinterleaver_ctrl_if.sv | 36 +++
 rtl/il_sym_counter.sv | 35 +++
 rtl/deinterleaver_ctrl.sv | 164 ++++++++++++++++
 tb/tb_deinterleaver_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wlan_il_pkg.sv
// Shared definitions for the 802.11a interleaver/deinterleaver controllers:
// coded-bits-per-symbol constants, selector decode and controller state encoding.
package wlan_il_pkg;

    localparam int ADDR_W = 9;

    localparam int NCBPS_48  = 48;
    localparam int NCBPS_96  = 96;
    localparam int NCBPS_192 = 192;
    localparam int NCBPS_288 = 288;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } il_state_t;

    function automatic logic [ADDR_W-1:0] ncbps_of(input logic [1:0] sel);
        logic [ADDR_W-1:0] n;
        n = ADDR_W'(NCBPS_48);
        case (sel)
            2'd0: n = ADDR_W'(NCBPS_48);
            2'd1: n = ADDR_W'(NCBPS_96);
            2'd2: n = ADDR_W'(NCBPS_192);
            2'd3: n = ADDR_W'(NCBPS_288);
            default: n = ADDR_W'(NCBPS_48);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/deinterleaver_ctrl_if.sv
// Configuration, input handshake and symbol-RAM steering bundle of the deinterleaver controller.
interface deinterleaver_ctrl_if #(
    parameter int NSYM_W = 12,
    parameter int ADDR_W = 9
);
    logic              cfg_valid;
    logic [1:0]        cfg_ncbps_sel;
    logic [NSYM_W-1:0] cfg_nsym;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_idx;
    logic [1:0]        ncbps_sel;
    logic              out_valid;
    logic              sym_done;
    logic              frame_done;
    logic              busy;

    // RX control / demapper side
    modport master (
        output cfg_valid, cfg_ncbps_sel, cfg_nsym, in_valid,
        input  in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_idx,
               ncbps_sel, out_valid, sym_done, frame_done, busy
    );

    // Controller side
    modport slave (
        input  cfg_valid, cfg_ncbps_sel, cfg_nsym, in_valid,
        output in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_idx,
               ncbps_sel, out_valid, sym_done, frame_done, busy
    );
endinterface

// File: rtl/il_sym_counter.sv
// Index counter that wraps at a runtime limit; done flags the increment that wraps.
module il_sym_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == limit) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = en && (cnt_q == limit);

endmodule

// File: rtl/deinterleaver_ctrl.sv
// Ping-pong sequencing controller for the 802.11a deinterleaver: one bank fills
// in interleaved order while the other drains, with frame progress reporting.
module deinterleaver_ctrl #(
    parameter int NSYM_W = 12,
    parameter int ADDR_W = 9
) (
    input  logic                clk,
    input  logic                reset,
    deinterleaver_ctrl_if.slave bus
);
    import wlan_il_pkg::*;

    il_state_t         state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [NSYM_W-1:0] nsym_q, nsym_d;
    logic [NSYM_W-1:0] wr_sym_q, wr_sym_d;
    logic [NSYM_W-1:0] rd_sym_q, rd_sym_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic              out_valid_q, out_valid_d;

    logic              in_ready;
    logic              wr_en;
    logic              rd_en;
    logic              wr_done;
    logic              rd_done;
    logic              last_wr;
    logic              last_rd;
    logic              cnt_clr;
    logic [ADDR_W-1:0] limit;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_idx;
    logic [NSYM_W-1:0] cfg_nsym_eff;

    assign limit        = ADDR_W'(ncbps_of(sel_q)) - ADDR_W'(1);
    assign cfg_nsym_eff = (bus.cfg_nsym == '0) ? NSYM_W'(1) : bus.cfg_nsym;

    // A bank is writable only once drained and readable only once filled, so the
    // write and read strobes can never address the same bank in one cycle.
    assign in_ready = ((state_q == ST_FILL) || (state_q == ST_STREAM)) && !full_q[wr_bank_q];
    assign wr_en    = bus.in_valid && in_ready;
    assign rd_en    = ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && full_q[rd_bank_q];

    assign last_wr  = wr_done && ((wr_sym_q + NSYM_W'(1)) == nsym_q);
    assign last_rd  = rd_done && ((rd_sym_q + NSYM_W'(1)) == nsym_q);

    il_sym_counter #(.W(ADDR_W)) u_wr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (wr_en),
        .limit (limit),
        .cnt   (wr_addr),
        .done  (wr_done)
    );

    il_sym_counter #(.W(ADDR_W)) u_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (rd_en),
        .limit (limit),
        .cnt   (rd_idx),
        .done  (rd_done)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        nsym_d    = nsym_q;
        wr_sym_d  = wr_sym_q;
        rd_sym_d  = rd_sym_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        cnt_clr   = 1'b0;

        // Write and read pointers advance independently; a read bank that is not
        // yet full simply stalls rd_en until the writer completes it.
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_sym_d          = wr_sym_q + NSYM_W'(1);
        end
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_sym_d          = rd_sym_q + NSYM_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    sel_d     = bus.cfg_ncbps_sel;
                    nsym_d    = cfg_nsym_eff;
                    wr_sym_d  = '0;
                    rd_sym_d  = '0;
                    wr_bank_d = 1'b0;
                    rd_bank_d = 1'b0;
                    full_d    = 2'b00;
                    cnt_clr   = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (wr_done) begin
                    state_d = last_wr ? ST_DRAIN : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (last_wr) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_rd) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid_d = rd_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            nsym_q      <= '0;
            wr_sym_q    <= '0;
            rd_sym_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            nsym_q      <= nsym_d;
            wr_sym_q    <= wr_sym_d;
            rd_sym_q    <= rd_sym_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wr_en      = wr_en;
    assign bus.wr_bank    = wr_bank_q;
    assign bus.wr_addr    = wr_addr;
    assign bus.rd_en      = rd_en;
    assign bus.rd_bank    = rd_bank_q;
    assign bus.rd_idx     = rd_idx;
    assign bus.ncbps_sel  = sel_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.sym_done   = rd_done;
    assign bus.frame_done = last_rd;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_deinterleaver_ctrl.sv
// Scoreboard bench for deinterleaver_ctrl: per-frame write/read sequences are queued at
// configuration time and popped by a cycle monitor driven by a symbol-occupancy model.
module tb_deinterleaver_ctrl;
    localparam int NSYM_W = 12;
    localparam int ADDR_W = 9;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    deinterleaver_ctrl_if #(.NSYM_W(NSYM_W), .ADDR_W(ADDR_W)) bus();

    deinterleaver_ctrl #(.NSYM_W(NSYM_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int bank;
        int idx;
        int sd;
        int fd;
    } ev_t;

    ev_t wq[$];
    ev_t rq[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int iv_mode = 0;

    // occupancy model: symbols fully written / fully read in the current frame
    bit m_active = 0;
    bit m_prev_rd = 0;
    int m_sel = 0, m_nsym = 1, m_n = 48;
    int m_wsym = 0, m_rsym = 0, m_wbits = 0, m_rbits = 0;

    int sym_cnt, frame_cnt, stall_cnt;
    int first_wr_cyc, sym0_last_wr_cyc, first_rd_cyc, frame_end_cyc;

    function automatic int tb_ncbps(input int sel);
        int tbl[4] = '{48, 96, 192, 288};
        return tbl[sel];
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},       int'(bus.busy), 0);
        chk({tag, "_in_ready"},   int'(bus.in_ready), 0);
        chk({tag, "_wr_en"},      int'(bus.wr_en), 0);
        chk({tag, "_rd_en"},      int'(bus.rd_en), 0);
        chk({tag, "_out_valid"},  int'(bus.out_valid), 0);
        chk({tag, "_sym_done"},   int'(bus.sym_done), 0);
        chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
        chk({tag, "_wr_addr"},    int'(bus.wr_addr), 0);
        chk({tag, "_rd_idx"},     int'(bus.rd_idx), 0);
        chk({tag, "_wr_bank"},    int'(bus.wr_bank), 0);
        chk({tag, "_rd_bank"},    int'(bus.rd_bank), 0);
        chk({tag, "_ncbps_sel"},  int'(bus.ncbps_sel), 0);
    endtask

    always @(negedge clk) begin
        bit exp_ir, exp_rd, exp_wr, was_active;
        ev_t e;
        cyc++;
        if (!reset) begin
            check_all_zero("in_reset");
            m_active  = 0;
            m_prev_rd = 0;
            m_sel     = 0;
            wq.delete();
            rq.delete();
        end else begin
            was_active = m_active;
            exp_ir = m_active && (m_wsym < m_nsym) && ((m_wsym - m_rsym) < 2);
            exp_rd = m_active && (m_rsym < m_wsym);
            exp_wr = bus.in_valid && exp_ir;

            chk("busy",      int'(bus.busy), int'(m_active));
            chk("in_ready",  int'(bus.in_ready), int'(exp_ir));
            chk("wr_en",     int'(bus.wr_en), int'(exp_wr));
            chk("rd_en",     int'(bus.rd_en), int'(exp_rd));
            chk("out_valid", int'(bus.out_valid), int'(m_prev_rd));
            chk("ncbps_sel", int'(bus.ncbps_sel), m_sel);

            if (bus.wr_en && bus.rd_en) begin
                n_chk++;
                assert (bus.wr_bank != bus.rd_bank) n_pass++;
                else $display("FAIL bank_clash: wr_bank %0d rd_bank %0d (cycle %0d)",
                              bus.wr_bank, bus.rd_bank, cyc);
            end

            if (bus.wr_en && first_wr_cyc < 0) first_wr_cyc = cyc;
            if (bus.wr_en && sym0_last_wr_cyc < 0 && int'(bus.wr_addr) == m_n - 1)
                sym0_last_wr_cyc = cyc;
            if (bus.rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (bus.sym_done) sym_cnt++;
            if (bus.frame_done) begin
                frame_cnt++;
                frame_end_cyc = cyc;
            end
            if (bus.busy && !bus.rd_en && sym_cnt > 0) stall_cnt++;

            if (exp_wr) begin
                if (wq.size() == 0) begin
                    chk("wr_queue_underflow", 1, 0);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addr", int'(bus.wr_addr), e.idx);
                    chk("wr_bank", int'(bus.wr_bank), e.bank);
                end
                m_wbits++;
                if (m_wbits == m_n) begin
                    m_wbits = 0;
                    m_wsym++;
                end
            end

            if (exp_rd) begin
                if (rq.size() == 0) begin
                    chk("rd_queue_underflow", 1, 0);
                end else begin
                    e = rq.pop_front();
                    chk("rd_idx",     int'(bus.rd_idx), e.idx);
                    chk("rd_bank",    int'(bus.rd_bank), e.bank);
                    chk("sym_done",   int'(bus.sym_done), e.sd);
                    chk("frame_done", int'(bus.frame_done), e.fd);
                end
                m_rbits++;
                if (m_rbits == m_n) begin
                    m_rbits = 0;
                    m_rsym++;
                    if (m_rsym == m_nsym) m_active = 0;
                end
            end else begin
                chk("sym_done_idle",   int'(bus.sym_done), 0);
                chk("frame_done_idle", int'(bus.frame_done), 0);
            end

            if (!was_active && bus.cfg_valid) begin
                m_active = 1;
                m_sel    = int'(bus.cfg_ncbps_sel);
                m_nsym   = (bus.cfg_nsym == 0) ? 1 : int'(bus.cfg_nsym);
                m_n      = tb_ncbps(m_sel);
                m_wsym   = 0;
                m_rsym   = 0;
                m_wbits  = 0;
                m_rbits  = 0;
            end
            m_prev_rd = exp_rd;
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (iv_mode)
                1: bus.in_valid = 1'b1;
                2: bus.in_valid = ~bus.in_valid;
                3: bus.in_valid = ($urandom_range(0, 3) != 0);
                default: bus.in_valid = 1'b0;
            endcase
        end
    end

    task automatic clear_stats();
        sym_cnt = 0;
        frame_cnt = 0;
        stall_cnt = 0;
        first_wr_cyc = -1;
        sym0_last_wr_cyc = -1;
        first_rd_cyc = -1;
        frame_end_cyc = -1;
    endtask

    task automatic start_frame(input int sel, input int nsym);
        int ns = (nsym == 0) ? 1 : nsym;
        int n = tb_ncbps(sel);
        for (int s = 0; s < ns; s++)
            for (int k = 0; k < n; k++)
                wq.push_back('{s % 2, k, 0, 0});
        for (int s = 0; s < ns; s++)
            for (int i = 0; i < n; i++)
                rq.push_back('{s % 2, i, int'(i == n - 1), int'((s == ns - 1) && (i == n - 1))});
        @(posedge clk);
        #1;
        bus.cfg_valid     = 1'b1;
        bus.cfg_ncbps_sel = 2'(sel);
        bus.cfg_nsym      = NSYM_W'(nsym);
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int i = 0;
        while (bus.busy && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_timeout"}, int'(i < bound), 1);
        chk({tag, "_wq_left"}, wq.size(), 0);
        chk({tag, "_rq_left"}, rq.size(), 0);
    endtask

    initial begin
        int found;
        int sel, nsym;
        clear_stats();
        bus.cfg_valid     = 1'b0;
        bus.cfg_ncbps_sel = 2'd0;
        bus.cfg_nsym      = '0;

        // reset with a configuration attempt while held in reset
        @(posedge clk);
        #1;
        bus.cfg_valid     = 1'b1;
        bus.cfg_ncbps_sel = 2'd3;
        bus.cfg_nsym      = NSYM_W'(5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.cfg_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("post_reset");

        // single symbol, 48 bits, continuous input
        iv_mode = 1;
        repeat (2) @(posedge clk);
        clear_stats();
        start_frame(0, 1);
        wait_idle(500, "t_single");
        chk("t_single_latency", first_rd_cyc - first_wr_cyc, 48);
        chk("t_single_end", frame_end_cyc - first_rd_cyc, 47);
        chk("t_single_sym", sym_cnt, 1);
        chk("t_single_frame", frame_cnt, 1);

        // streaming, 4 x 288 continuous
        clear_stats();
        start_frame(3, 4);
        wait_idle(3000, "t_stream");
        chk("t_stream_span", frame_end_cyc - first_rd_cyc + 1, 4 * 288);
        chk("t_stream_sym", sym_cnt, 4);
        chk("t_stream_frame", frame_cnt, 1);

        // gapped input, 96-bit symbols, in_valid alternating
        iv_mode = 2;
        clear_stats();
        start_frame(1, 2);
        wait_idle(3000, "t_gap");
        chk("t_gap_fill", sym0_last_wr_cyc - first_wr_cyc, 2 * (96 - 1));
        chk("t_gap_stalled", int'(stall_cnt > 0), 1);
        chk("t_gap_sym", sym_cnt, 2);
        chk("t_gap_frame", frame_cnt, 1);

        // reconfiguration while busy is ignored
        iv_mode = 1;
        clear_stats();
        start_frame(0, 2);
        repeat (20) @(posedge clk);
        #1;
        bus.cfg_valid     = 1'b1;
        bus.cfg_ncbps_sel = 2'd2;
        bus.cfg_nsym      = NSYM_W'(7);
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
        chk("t_reconf_sel_held", int'(bus.ncbps_sel), 0);
        wait_idle(1000, "t_reconf_a");
        chk("t_reconf_sym", sym_cnt, 2);
        chk("t_reconf_frame", frame_cnt, 1);
        start_frame(2, 1);
        wait_idle(1000, "t_reconf_b");
        chk("t_reconf_sel_new", int'(bus.ncbps_sel), 2);
        chk("t_reconf_frame2", frame_cnt, 2);

        // abort mid-stream
        clear_stats();
        start_frame(3, 3);
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            @(negedge clk);
            if (bus.rd_en && bus.rd_idx == ADDR_W'(100)) found = 1;
        end
        chk("t_abort_reached", found, 1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("t_abort_immediate");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("t_abort_no_frame_done", frame_cnt, 0);
        iv_mode = 3;
        clear_stats();
        start_frame(3, 2);
        wait_idle(4000, "t_abort_restart");
        chk("t_abort_restart_sym", sym_cnt, 2);
        chk("t_abort_restart_frame", frame_cnt, 1);

        // randomized frames, including nsym = 0
        for (int f = 0; f < 4; f++) begin
            sel  = $urandom_range(0, 3);
            nsym = $urandom_range(0, 3);
            clear_stats();
            start_frame(sel, nsym);
            wait_idle(8000, "t_rand");
            chk("t_rand_sym", sym_cnt, (nsym == 0) ? 1 : nsym);
            chk("t_rand_frame", frame_cnt, 1);
        end

        iv_mode = 0;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
